unidad_control_booth: RTL and testbench
=======================================

// Module: unidad_control_booth
// PURPOSE
//  Sequencer for the radix-2 Booth multiplier datapath (registers A, Q, M, bit Q-1).
//  Accepts a start request, loads operands, then runs N iterations of
//  evaluate / add-or-subtract / arithmetic shift, and signals completion.
//  Sits between the top-level user logic (start/Fin) and the datapath enables.
// PARAMETERS
//  N    4   operand width = number of Booth iterations (N >= 1)
// PORTS
//  clk          in   1  system clock, all state changes on rising edge
//  reset        in   1  synchronous, active-high; forces IDLE on next rising edge
//  start        in   1  request a multiplication; sampled only in IDLE
//  q0           in   1  datapath Q[0]
//  qsub1        in   1  datapath Q-1 bit
//  CargaQ       out  1  load multiplier into Q, clear Q-1
//  CargaM       out  1  load multiplicand into M
//  ResetA       out  1  clear A
//  CargaA       out  1  write adder/subtractor result into A
//  RestaA       out  1  adder mode: 1 = A-M, 0 = A+M (valid while CargaA=1, else 0)
//  DesplazaAQ   out  1  arithmetic right shift of A:Q:Q-1
//  Ocupado      out  1  1 whenever state != IDLE
//  Fin          out  1  one-cycle completion pulse
// BEHAVIOUR
//  - All outputs are Moore, decoded from the registered state only.
//  - Iteration counter cnt, width $clog2(N+1), unsigned.
//  - Reset (sync): state=IDLE, cnt=0; all outputs 0 in the following cycle.
//  - States and transitions:
//    IDLE : no outputs. start=1 -> LOAD; else stay.
//    LOAD : CargaQ=CargaM=ResetA=1; cnt<=N; -> EVAL.
//    EVAL : no outputs; {q0,qsub1}: 10 -> SUB, 01 -> ADD, 00/11 -> SHIFT.
//    ADD  : CargaA=1, RestaA=0; -> SHIFT.
//    SUB  : CargaA=1, RestaA=1; -> SHIFT.
//    SHIFT: DesplazaAQ=1; cnt<=cnt-1; cnt==1 -> DONE, else -> EVAL.
//    DONE : Fin=1 (exactly one cycle); -> IDLE unconditionally.
//  - Unused state encodings -> IDLE next cycle, all outputs 0.
//  - q0/qsub1 sampled only in EVAL (after previous shift has settled).
//  - Latency: start accepted at edge k -> LOAD in cycle k+1; each iteration
//    costs 2 cycles (00/11) or 3 cycles (01/10); DONE follows last SHIFT.
//    Total from LOAD to Fin inclusive = 2 + sum(iteration costs); N=4 range 10..14.
//  - start high during non-IDLE states ignored (no queueing); start still high
//    when returning to IDLE from DONE starts a new operation (LOAD next cycle).
//  - Ocupado=1 in LOAD..DONE inclusive, 0 only in IDLE.
//  - At most one of CargaA / DesplazaAQ / CargaQ asserted in any cycle.
//  - reset has priority over every transition, including mid-iteration and DONE;
//    Fin is never emitted for an aborted operation.
// TESTING
//  1. reset=1 two cycles, start=0 -> all outputs 0, Ocupado=0, stays IDLE.
//  2. N=4, start pulse, {q0,qsub1}=00 each EVAL -> LOAD,(EVAL,SHIFT)x4,DONE;
//     exactly 4 DesplazaAQ pulses, 0 CargaA, Fin 10 cycles after LOAD start.
//  3. N=4, EVAL pairs 10,01,11,10 -> SUB,ADD,-,SUB; CargaA=3 pulses with
//     RestaA=1,0,1; 4 shifts; Fin at cycle 13 counting LOAD as 1.
//  4. start held high continuously -> Fin pulse, one IDLE cycle, LOAD again;
//     Ocupado drops for exactly that one cycle.
//  5. reset asserted in 2nd SHIFT -> IDLE next edge, outputs 0, no Fin;
//     subsequent start runs a full N=4 sequence with cnt reloaded to 4.
//  6. N=1 build, pair 01 -> LOAD,EVAL,ADD,SHIFT,DONE; one CargaA, one shift.

Source files
------------

// File: rtl/unidad_control_booth.sv
// Control sequencer for a radix-2 Booth multiplier datapath.
// Loads the operands, runs N evaluate / add-or-subtract / shift iterations
// and emits a one-cycle Fin pulse. Every output is Moore-decoded from the
// registered state. The current state is also presented on state_dbg_o.
//
// Handshake: start is a level request. It is looked at only in IDLE, and
// never queued. Ocupado reports that an operation is in flight, and Fin
// marks the single cycle in which that operation completes.
module unidad_control_booth #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q0,
  input  logic       qsub1,
  output logic       CargaQ,
  output logic       CargaM,
  output logic       ResetA,
  output logic       CargaA,
  output logic       RestaA,
  output logic       DesplazaAQ,
  output logic       Ocupado,
  output logic       Fin,
  output logic [2:0] state_dbg_o
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and iteration counter registers. Reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update. q0/qsub1 are only consulted in EVAL,
  // after the previous shift has settled into the datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = CW'(N);
        state_d = S_EVAL;
      end
      S_EVAL: begin
        case ({q0, qsub1})
          2'b10:   state_d = S_SUB;
          2'b01:   state_d = S_ADD;
          default: state_d = S_SHIFT;
        endcase
      end
      S_ADD:   state_d = S_SHIFT;
      S_SUB:   state_d = S_SHIFT;
      S_SHIFT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? S_DONE : S_EVAL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode. The unused encoding falls into the all-zero default.
  always_comb begin
    CargaQ     = 1'b0;
    CargaM     = 1'b0;
    ResetA     = 1'b0;
    CargaA     = 1'b0;
    RestaA     = 1'b0;
    DesplazaAQ = 1'b0;
    Ocupado    = 1'b0;
    Fin        = 1'b0;
    case (state_q)
      S_LOAD: begin
        CargaQ  = 1'b1;
        CargaM  = 1'b1;
        ResetA  = 1'b1;
        Ocupado = 1'b1;
      end
      S_EVAL: Ocupado = 1'b1;
      S_ADD: begin
        CargaA  = 1'b1;
        Ocupado = 1'b1;
      end
      S_SUB: begin
        CargaA  = 1'b1;
        RestaA  = 1'b1;
        Ocupado = 1'b1;
      end
      S_SHIFT: begin
        DesplazaAQ = 1'b1;
        Ocupado    = 1'b1;
      end
      S_DONE: begin
        Fin     = 1'b1;
        Ocupado = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_unidad_control_booth.sv
// Directed bench for unidad_control_booth. It uses an N=4 instance and an
// N=1 instance. Each step drives one cycle of inputs and pushes the expected
// {state, outputs} vector, which is then compared after the next rising edge.
module tb_unidad_control_booth;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SUB   = 3'd4;
  localparam logic [2:0] S_SHIFT = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       reset, start, q0, qsub1;
  logic       cq, cm, ra, ca, rs, sh, oc, fn;
  logic [2:0] st_dbg;
  // N=1 instance
  logic       reset1, start1, q01, qsub11;
  logic       cq1, cm1, ra1, ca1, rs1, sh1, oc1, fn1;
  logic [2:0] st_dbg1;

  unidad_control_booth #(.N(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0), .qsub1(qsub1),
    .CargaQ(cq), .CargaM(cm), .ResetA(ra), .CargaA(ca), .RestaA(rs),
    .DesplazaAQ(sh), .Ocupado(oc), .Fin(fn), .state_dbg_o(st_dbg)
  );

  unidad_control_booth #(.N(1)) u_dut1 (
    .clk(clk), .reset(reset1), .start(start1), .q0(q01), .qsub1(qsub11),
    .CargaQ(cq1), .CargaM(cm1), .ResetA(ra1), .CargaA(ca1), .RestaA(rs1),
    .DesplazaAQ(sh1), .Ocupado(oc1), .Fin(fn1), .state_dbg_o(st_dbg1)
  );

  // scoreboard
  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_shift, n_carga, n_fin, cyc, load_cyc, fin_cyc;
  logic [2:0] resta_log;

  // Expected {state, CargaQ,CargaM,ResetA,CargaA,RestaA,DesplazaAQ,Ocupado,Fin}.
  function automatic logic [10:0] vec(input logic [2:0] s);
    case (s)
      S_LOAD:  return {s, 8'b1110_0010};
      S_EVAL:  return {s, 8'b0000_0010};
      S_ADD:   return {s, 8'b0001_0010};
      S_SUB:   return {s, 8'b0001_1010};
      S_SHIFT: return {s, 8'b0000_0110};
      S_DONE:  return {s, 8'b0000_0011};
      default: return {s, 8'b0000_0000};
    endcase
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_counts();
    n_shift = 0; n_carga = 0; n_fin = 0; cyc = 0;
    load_cyc = -1; fin_cyc = -1; resta_log = 3'b000;
  endtask

  // Drive one cycle. use1 selects the N=1 instance; the idle one is held in reset.
  task automatic step(input string tag, input bit use1, input logic rst,
                      input logic st, input logic a, input logic b,
                      input logic [2:0] es);
    logic [10:0] obs;
    logic [10:0] e;
    if (use1) begin
      reset = 1'b1; start = 1'b0; q0 = 1'b0; qsub1 = 1'b0;
      reset1 = rst; start1 = st; q01 = a; qsub11 = b;
    end else begin
      reset1 = 1'b1; start1 = 1'b0; q01 = 1'b0; qsub11 = 1'b0;
      reset = rst; start = st; q0 = a; qsub1 = b;
    end
    exp_q.push_back(vec(es));
    @(posedge clk);
    #1;
    obs = use1 ? {st_dbg1, cq1, cm1, ra1, ca1, rs1, sh1, oc1, fn1}
               : {st_dbg,  cq,  cm,  ra,  ca,  rs,  sh,  oc,  fn};
    cyc++;
    if (obs[7]) load_cyc = cyc;
    if (obs[0]) begin n_fin++; fin_cyc = cyc; end
    if (obs[2]) n_shift++;
    if (obs[4]) begin n_carga++; resta_log = {resta_log[1:0], obs[3]}; end
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // One Booth iteration entered from LOAD or SHIFT: EVAL, optional ADD/SUB, SHIFT.
  task automatic iter(input string tag, input bit use1, input logic st,
                      input logic [1:0] pr);
    step({tag, "_eval"}, use1, 1'b0, st, pr[1], pr[0], S_EVAL);
    if (pr == 2'b10) begin
      step({tag, "_sub"}, use1, 1'b0, st, pr[1], pr[0], S_SUB);
      step({tag, "_shift"}, use1, 1'b0, st, 1'b0, 1'b0, S_SHIFT);
    end else if (pr == 2'b01) begin
      step({tag, "_add"}, use1, 1'b0, st, pr[1], pr[0], S_ADD);
      step({tag, "_shift"}, use1, 1'b0, st, 1'b0, 1'b0, S_SHIFT);
    end else begin
      step({tag, "_shift"}, use1, 1'b0, st, pr[1], pr[0], S_SHIFT);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; q0 = 1'b0; qsub1 = 1'b0;
    reset1 = 1'b1; start1 = 1'b0; q01 = 1'b0; qsub11 = 1'b0;
    clear_counts();

    // 1. reset for two cycles, then stay idle
    step("rst0", 0, 1, 0, 0, 0, S_IDLE);
    step("rst1", 0, 1, 0, 0, 0, S_IDLE);
    step("idle_hold", 0, 0, 0, 1, 0, S_IDLE);

    // 2. all-00 pairs: four shifts, no adds, Fin 10 cycles after LOAD
    clear_counts();
    step("t2_load", 0, 0, 1, 0, 0, S_LOAD);
    for (int i = 0; i < 4; i++) iter("t2", 0, 1'b0, 2'b00);
    step("t2_done", 0, 0, 0, 0, 0, S_DONE);
    step("t2_idle", 0, 0, 0, 0, 0, S_IDLE);
    check_int("t2_shifts", n_shift, 4);
    check_int("t2_cargaA", n_carga, 0);
    check_int("t2_fin_count", n_fin, 1);
    check_int("t2_latency", fin_cyc - load_cyc + 1, 10);

    // 3. pairs 10,01,11,10 -> SUB, ADD, shift only, SUB
    clear_counts();
    step("t3_load", 0, 0, 1, 0, 0, S_LOAD);
    iter("t3_i1", 0, 1'b0, 2'b10);
    iter("t3_i2", 0, 1'b0, 2'b01);
    iter("t3_i3", 0, 1'b0, 2'b11);
    iter("t3_i4", 0, 1'b0, 2'b10);
    step("t3_done", 0, 0, 0, 0, 0, S_DONE);
    step("t3_idle", 0, 0, 0, 0, 0, S_IDLE);
    check_int("t3_cargaA", n_carga, 3);
    check_int("t3_resta_seq", int'(resta_log), 3'b101);
    check_int("t3_shifts", n_shift, 4);
    check_int("t3_latency", fin_cyc - load_cyc + 1, 13);

    // 4. start held high: Fin, one IDLE cycle, LOAD again
    clear_counts();
    step("t4_load", 0, 0, 1, 0, 0, S_LOAD);
    for (int i = 0; i < 4; i++) iter("t4", 0, 1'b1, 2'b00);
    step("t4_done", 0, 0, 1, 0, 0, S_DONE);
    step("t4_idle_gap", 0, 0, 1, 0, 0, S_IDLE);
    step("t4_reload", 0, 0, 1, 0, 0, S_LOAD);
    check_int("t4_fin_count", n_fin, 1);
    step("t4_rst", 0, 1, 0, 0, 0, S_IDLE);

    // 5. reset during the second SHIFT aborts without Fin; next run is full length
    clear_counts();
    step("t5_load", 0, 0, 1, 0, 0, S_LOAD);
    iter("t5_a1", 0, 1'b0, 2'b00);
    iter("t5_a2", 0, 1'b0, 2'b01);
    step("t5_abort", 0, 1, 0, 0, 0, S_IDLE);
    step("t5_after", 0, 0, 0, 0, 0, S_IDLE);
    check_int("t5_no_fin", n_fin, 0);
    clear_counts();
    step("t5_load2", 0, 0, 1, 0, 0, S_LOAD);
    iter("t5_b1", 0, 1'b0, 2'b11);
    iter("t5_b2", 0, 1'b0, 2'b10);
    iter("t5_b3", 0, 1'b0, 2'b00);
    iter("t5_b4", 0, 1'b0, 2'b01);
    step("t5_done", 0, 0, 0, 0, 0, S_DONE);
    step("t5_idle", 0, 0, 0, 0, 0, S_IDLE);
    check_int("t5_shifts", n_shift, 4);
    check_int("t5_latency", fin_cyc - load_cyc + 1, 12);

    // 6. N=1 instance, pair 01
    step("t6_rst", 1, 1, 0, 0, 0, S_IDLE);
    clear_counts();
    step("t6_load", 1, 0, 1, 0, 0, S_LOAD);
    iter("t6", 1, 1'b0, 2'b01);
    step("t6_done", 1, 0, 0, 0, 0, S_DONE);
    step("t6_idle", 1, 0, 0, 0, 0, S_IDLE);
    check_int("t6_cargaA", n_carga, 1);
    check_int("t6_shifts", n_shift, 1);
    check_int("t6_fin_count", n_fin, 1);

    check_int("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
